// File: rtl/baby_nibble_accumulator_pkg.sv
// Shared definitions for the Baby nibble-serial accumulator.
//   - BABY_WORD_WIDTH : native Baby store word width
//   - OP_*            : operation encodings presented on the op port
//   - ST_*            : control FSM state encodings
//   - is_subtract()   : true for the ops that go through the two's complement subtract path
package baby_nibble_accumulator_pkg;

    localparam int BABY_WORD_WIDTH = 32;

    localparam logic [1:0] OP_LDN  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic logic is_subtract(input logic [1:0] op_code);
        return (op_code == OP_LDN) || (op_code == OP_SUB);
    endfunction

endpackage

// File: rtl/baby_nibble_accumulator_ttl283_adder.sv
// ttl283_adder: behavioural model of a single 74x283 4-bit binary full adder.
//   a, b : 4-bit addends
//   c0   : carry in
//   s    : 4-bit sum
//   c4   : carry out
module ttl283_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       c4
);

    assign {c4, s} = {1'b0, a} + {1'b0, b} + {4'b0000, c0};

endmodule

// File: rtl/baby_nibble_accumulator.sv
// baby_nibble_accumulator: Baby accumulator computed nibble-serially through one
// ttl283_adder slice, one nibble per clock, LSB nibble first, with a registered
// carry between slices. Supports LDN (acc = -operand), SUB (acc = acc - operand),
// LOAD (acc = operand) and NOP.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   start    : operation request, sampled only while idle
//   op       : operation code, sampled with start
//   operand  : store word, sampled with start
//   busy     : high while an operation is in flight
//   done     : one-cycle pulse, acc holds the new result in this cycle
//   acc      : committed accumulator (never shows partial results)
//   negative : sign of the committed accumulator
// WIDTH must be a multiple of 4 and at least 8.
module baby_nibble_accumulator
    import baby_nibble_accumulator_pkg::*;
#(
    parameter int WIDTH = BABY_WORD_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] acc,
    output logic             negative
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W   = $clog2(NIBBLES);

    logic [0:0]       state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] opnd_sr;
    logic [WIDTH-1:0] a_sr;
    // Only WIDTH-4 bits are kept: the final nibble comes straight from the
    // adder on the commit edge, so the full word is {slice_s, res_sr}.
    logic [WIDTH-5:0] res_sr;
    logic             carry;
    logic [CNT_W-1:0] count;
    logic             done_q;
    logic [WIDTH-1:0] acc_q;

    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic             slice_c0;
    logic [3:0]       slice_s;
    logic             slice_c4;
    logic [WIDTH-1:0] result_full;
    logic             last_nibble;

    // Subtraction is A + ~B + 1: the initial carry of 1 supplies the +1 and
    // the inverted operand nibbles supply ~B. LOAD adds the operand to zero.
    always_comb begin
        slice_a  = 4'h0;
        slice_b  = opnd_sr[3:0];
        slice_c0 = 1'b0;
        if (is_subtract(op_q)) begin
            slice_a  = a_sr[3:0];
            slice_b  = ~opnd_sr[3:0];
            slice_c0 = carry;
        end
    end

    ttl283_adder u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .c0 (slice_c0),
        .s  (slice_s),
        .c4 (slice_c4)
    );

    assign result_full = {slice_s, res_sr};
    assign last_nibble = (count == CNT_W'(NIBBLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            op_q    <= OP_LDN;
            opnd_sr <= '0;
            a_sr    <= '0;
            res_sr  <= '0;
            carry   <= 1'b0;
            count   <= '0;
            done_q  <= 1'b0;
            acc_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        opnd_sr <= operand;
                        // LDN is computed as 0 - operand.
                        a_sr    <= (op == OP_LDN) ? '0 : acc_q;
                        carry   <= is_subtract(op);
                        count   <= '0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    res_sr  <= result_full[WIDTH-1:4];
                    carry   <= slice_c4;
                    a_sr    <= {4'h0, a_sr[WIDTH-1:4]};
                    opnd_sr <= {4'h0, opnd_sr[WIDTH-1:4]};
                    if (last_nibble) begin
                        // Final carry out is dropped: arithmetic is modulo 2^WIDTH.
                        if (op_q != OP_NOP) begin
                            acc_q <= result_full;
                        end
                        done_q <= 1'b1;
                        count  <= '0;
                        state  <= ST_IDLE;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state == ST_RUN);
    assign done     = done_q;
    assign acc      = acc_q;
    assign negative = acc_q[WIDTH-1];

endmodule

// File: tb/tb_baby_nibble_accumulator.sv
module tb_baby_nibble_accumulator;

    localparam int W   = 32;
    localparam int NIB = W / 4;

    localparam logic [1:0] LDN  = 2'b00;
    localparam logic [1:0] SUB  = 2'b01;
    localparam logic [1:0] LOAD = 2'b10;
    localparam logic [1:0] NOP  = 2'b11;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] operand;
    logic         busy;
    logic         done;
    logic [W-1:0] acc;
    logic         negative;

    baby_nibble_accumulator #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .operand  (operand),
        .busy     (busy),
        .done     (done),
        .acc      (acc),
        .negative (negative)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    typedef struct {
        logic [W-1:0] acc;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] model_acc;
    int           checks = 0;
    int           errors = 0;
    int           dones_seen = 0;
    int           dones_expected = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: the Baby arithmetic stated directly as word arithmetic.
    function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (o)
            LDN:     return -b;
            SUB:     return a - b;
            LOAD:    return b;
            default: return a;
        endcase
    endfunction

    // Monitor: compares every done pulse against the head of the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && done) begin
            dones_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=acc %h required=no done pulse", acc);
            end else begin
                e = sb.pop_front();
                chk("acc", acc, e.acc);
                chk("negative", {31'b0, negative}, {31'b0, e.acc[W-1]});
                chk("done_latency", cycle, e.cyc);
                chk("busy_in_done_cycle", {31'b0, busy}, 32'd0);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout actual=busy required=idle");
        end
    endtask

    // Issues one operation at the first idle negedge; returns just after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] val);
        exp_t e;
        wait_idle();
        start     = 1'b1;
        op        = o;
        operand   = val;
        model_acc = ref_op(o, model_acc, val);
        e.acc     = model_acc;
        e.cyc     = cycle + 1 + NIB;
        sb.push_back(e);
        dones_expected++;
        @(posedge clk);
        #1;
        start   = 1'b0;
        op      = $urandom_range(3, 0);
        operand = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] v;
        logic [1:0]   o;
        reset_n   = 1'b0;
        start     = 1'b0;
        op        = LDN;
        operand   = '0;
        model_acc = '0;

        repeat (3) @(negedge clk);
        chk("reset_acc", acc, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_negative", {31'b0, negative}, 32'd0);
        reset_n = 1'b1;

        // LDN 5
        issue(LDN, 32'd5);
        drain();
        chk("ldn5_acc", acc, 32'hFFFF_FFFB);

        // LOAD 10, SUB 3, SUB 8
        issue(LOAD, 32'd10);
        issue(SUB, 32'd3);
        drain();
        chk("sub3_acc", acc, 32'd7);
        issue(SUB, 32'd8);
        drain();
        chk("sub8_wrap_acc", acc, 32'hFFFF_FFFF);

        // Back-to-back: second start lands in the done cycle
        issue(LOAD, 32'h1234_5678);
        issue(SUB, 32'h0000_0001);
        drain();
        chk("b2b_acc", acc, 32'h1234_5677);

        // Start while busy is ignored
        issue(LDN, 32'd1);
        repeat (2) @(negedge clk);
        start   = 1'b1;
        op      = LOAD;
        operand = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        chk("busy_start_ignored_acc", acc, 32'hFFFF_FFFF);

        // Most negative value edge cases
        issue(LOAD, 32'd0);
        issue(SUB, 32'h8000_0000);
        issue(LDN, 32'h8000_0000);
        issue(NOP, 32'h1234_5678);
        drain();
        chk("minint_acc", acc, 32'h8000_0000);

        // Reset mid-operation
        issue(LOAD, 32'h55);
        issue(SUB, 32'd1);
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        void'(sb.pop_back());
        dones_expected--;
        model_acc = '0;
        #1;
        chk("abort_acc", acc, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_acc_held", acc, 32'd0);
        issue(LDN, 32'd0);
        drain();
        chk("ldn0_after_abort", acc, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            o = 2'($urandom_range(3, 0));
            case ($urandom_range(5, 0))
                0:       v = 32'h8000_0000;
                1:       v = 32'hFFFF_FFFF;
                2:       v = 32'($urandom_range(15, 0));
                default: v = $urandom;
            endcase
            if ($urandom_range(2, 0) == 0) begin
                repeat ($urandom_range(3, 1)) @(negedge clk);
            end
            issue(o, v);
            if ($urandom_range(7, 0) == 0) begin
                repeat ($urandom_range(5, 0)) @(negedge clk);
                start   = 1'b1;
                op      = 2'($urandom_range(3, 0));
                operand = $urandom;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        drain();

        chk("scoreboard_empty", sb.size(), 32'd0);
        chk("done_count", dones_seen, dones_expected);
        chk("final_acc", acc, model_acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
